// File: rtl/channel_serializer.sv
// channel_serializer: splits one wide NIn-bit word into NChunks NOut-bit
// chunks, least-significant chunk first, over valid/ack channels.
//
// state | meaning
// IDLE  | no word held; in_a=1, out_v=0
// SEND  | presenting chunk idx of the held word; out_v=1
module channel_serializer #(
    parameter int NOut = 24,
    parameter int NIn  = 34
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIn-1:0]  in_d,
    input  logic            in_v,
    output logic            in_a,
    output logic [NOut-1:0] out_d,
    output logic            out_v,
    input  logic            out_a
);

    localparam int NChunks = (NIn + NOut - 1) / NOut;
    localparam int NCnt    = (NChunks > 1) ? $clog2(NChunks) : 1;
    localparam int NExt    = NChunks * NOut;
    localparam logic [NCnt-1:0] LastIdx = NCnt'(NChunks - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [NCnt-1:0]     idx_q, idx_d;
    logic [NIn-1:0]      word_q, word_d;
    logic [NExt-1:0]     word_ext;
    logic [NOut-1:0]     chunk;
    logic                busy;
    logic                last;

    assign busy = (state_q == SEND);
    assign last = (idx_q == LastIdx);

    // Zero-extend the held word and pick the chunk selected by idx.
    always_comb begin
        word_ext = '0;
        word_ext[NIn-1:0] = word_q;
        chunk = '0;
        for (int k = 0; k < NChunks; k++) begin
            if (idx_q == NCnt'(k)) begin
                chunk = word_ext[k*NOut +: NOut];
            end
        end
    end

    // Next-state and channel outputs; the out_a -> in_a path lets a new word
    // be taken on the cycle the last chunk leaves, so streams have no bubbles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        out_v   = busy;
        out_d   = busy ? chunk : '0;
        in_a    = reset & (~busy | (last & out_a));
        case (state_q)
            IDLE: begin
                if (in_v) begin
                    word_d  = in_d;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_a) begin
                    if (!last) begin
                        idx_d = idx_q + NCnt'(1);
                    end else if (in_v) begin
                        word_d = in_d;
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and word registers; reset discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_channel_serializer.sv
// Scoreboard bench for channel_serializer: a 34->24 instance and a
// degenerate 21->24 instance share clock and reset.
module tb_channel_serializer;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    logic [33:0] in_d_a;
    logic        in_v_a, in_a_a, out_v_a, out_a_a;
    logic [23:0] out_d_a;
    logic        out_a_dir, bp_en, bp_rand;

    logic [20:0] in_d_b;
    logic        in_v_b, in_a_b, out_v_b, out_a_b;
    logic [23:0] out_d_b;

    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];
    int          xcyc_a[$];
    int          xcyc_b[$];

    assign out_a_a = bp_en ? bp_rand : out_a_dir;

    channel_serializer #(.NOut(24), .NIn(34)) dut_a (
        .clk(clk), .reset(reset),
        .in_d(in_d_a), .in_v(in_v_a), .in_a(in_a_a),
        .out_d(out_d_a), .out_v(out_v_a), .out_a(out_a_a)
    );

    channel_serializer #(.NOut(24), .NIn(21)) dut_b (
        .clk(clk), .reset(reset),
        .in_d(in_d_b), .in_v(in_v_b), .in_a(in_a_b),
        .out_d(out_d_b), .out_v(out_v_b), .out_a(out_a_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 bp_rand = 1'($urandom_range(1, 0));
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor A: scoreboard pop, stall stability, and in_a vs chunk phase.
    logic        stall_a = 1'b0;
    logic [23:0] held_a = '0;
    logic        phase_a = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            stall_a = 1'b0;
            phase_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("a_hold_v", 64'(out_v_a), 64'd1);
                chk("a_hold_d", 64'(out_d_a), 64'(held_a));
            end
            if (out_v_a) chk("a_in_a", 64'(in_a_a), 64'(phase_a & out_a_a));
            else         chk("a_in_a_idle", 64'(in_a_a), 64'd1);
            if (out_v_a && out_a_a) begin
                xcyc_a.push_back(cyc);
                phase_a = ~phase_a;
                if (exp_a.size() == 0) begin
                    chk("a_unexpected", 64'(out_d_a), 64'hFFFF_FFFF);
                end else begin
                    chk("a_chunk", 64'(out_d_a), 64'(exp_a.pop_front()));
                end
            end
            stall_a = out_v_a && !out_a_a;
            held_a  = out_d_a;
        end
    end

    // Monitor B: scoreboard pop and stall stability.
    logic        stall_b = 1'b0;
    logic [23:0] held_b = '0;
    always @(negedge clk) begin
        if (!reset) begin
            stall_b = 1'b0;
        end else begin
            if (stall_b) begin
                chk("b_hold_v", 64'(out_v_b), 64'd1);
                chk("b_hold_d", 64'(out_d_b), 64'(held_b));
            end
            if (out_v_b && out_a_b) begin
                xcyc_b.push_back(cyc);
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", 64'(out_d_b), 64'hFFFF_FFFF);
                end else begin
                    chk("b_chunk", 64'(out_d_b), 64'(exp_b.pop_front()));
                end
            end
            stall_b = out_v_b && !out_a_b;
            held_b  = out_d_b;
        end
    end

    // Offer a word on A and return 1 ns after the accepting edge, in_v left high.
    task automatic send_a(input logic [33:0] w, input logic [23:0] c0, input logic [23:0] c1);
        logic acc;
        in_d_a = w;
        in_v_a = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            acc = in_a_a;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_a.push_back(c0);
                exp_a.push_back(c1);
                return;
            end
        end
        chk("a_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_b(input logic [20:0] w, input logic [23:0] c0);
        logic acc;
        in_d_b = w;
        in_v_b = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            acc = in_a_b;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_b.push_back(c0);
                return;
            end
        end
        chk("b_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(exp_a.size() + exp_b.size()), 64'd0);
    endtask

    task automatic chk_consecutive(input string name, input int q[$], input int want_n);
        chk({name, "_count"}, 64'(q.size()), 64'(want_n));
        for (int i = 1; i < q.size(); i++) begin
            chk({name, "_gap"}, 64'(q[i] - q[i-1]), 64'd1);
        end
    endtask

    initial begin
        logic [33:0] w;
        reset = 1'b0;
        in_d_a = '0; in_v_a = 1'b0; out_a_dir = 1'b1; bp_en = 1'b0;
        in_d_b = '0; in_v_b = 1'b0; out_a_b = 1'b1;

        #2;
        chk("rst_out_v", 64'(out_v_a), 64'd0);
        chk("rst_out_d", 64'(out_d_a), 64'd0);
        chk("rst_in_a",  64'(in_a_a),  64'd0);
        chk("rst_b_in_a", 64'(in_a_b), 64'd0);
        #10 reset = 1'b1;

        // Idle hold
        repeat (20) begin
            @(negedge clk);
            chk("idle_out_v", 64'(out_v_a), 64'd0);
            chk("idle_in_a",  64'(in_a_a),  64'd1);
        end
        @(posedge clk); #1;

        // Basic word, 1-cycle latency, in_a low during chunk 0
        send_a(34'h3_1234_5678, 24'h345678, 24'h000312);
        in_v_a = 1'b0;
        chk("basic_latency_v", 64'(out_v_a), 64'd1);
        chk("basic_chunk0_in_a", 64'(in_a_a), 64'd0);
        drain(50);
        repeat (2) @(posedge clk); #1;

        // Back-to-back stream
        xcyc_a.delete();
        send_a(34'h3_FFFF_FFFF, 24'hFFFFFF, 24'h0003FF);
        send_a(34'h0_0000_0001, 24'h000001, 24'h000000);
        send_a(34'h2_AAAA_AAAA, 24'hAAAAAA, 24'h0002AA);
        in_v_a = 1'b0;
        drain(50);
        @(posedge clk); #1;
        chk_consecutive("b2b", xcyc_a, 6);

        // Random backpressure over 200 words
        bp_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            w = {2'($urandom), 32'($urandom)};
            send_a(w, w[23:0], {14'd0, w[33:24]});
        end
        in_v_a = 1'b0;
        drain(5000);
        bp_en = 1'b0;
        out_a_dir = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Reset mid-word
        out_a_dir = 1'b0;
        send_a(34'h3_1234_5678, 24'h345678, 24'h000312);
        in_v_a = 1'b0;
        out_a_dir = 1'b1;
        @(posedge clk); #1;
        out_a_dir = 1'b0;
        chk("midrst_pre_v", 64'(out_v_a), 64'd1);
        #2 reset = 1'b0;
        exp_a.delete();
        #1;
        chk("midrst_out_v", 64'(out_v_a), 64'd0);
        chk("midrst_in_a",  64'(in_a_a),  64'd0);
        chk("midrst_out_d", 64'(out_d_a), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("postrst_in_a",  64'(in_a_a),  64'd1);
        chk("postrst_out_v", 64'(out_v_a), 64'd0);
        out_a_dir = 1'b1;
        @(posedge clk); #1;
        send_a(34'h0_0000_0005, 24'h000005, 24'h000000);
        in_v_a = 1'b0;
        drain(50);
        repeat (2) @(posedge clk); #1;

        // Degenerate single-chunk instance
        xcyc_b.delete();
        send_b(21'h1ABCDE, 24'h1ABCDE);
        chk("deg_latency_v", 64'(out_v_b), 64'd1);
        send_b(21'h000001, 24'h000001);
        in_v_b = 1'b0;
        drain(50);
        @(posedge clk); #1;
        chk_consecutive("deg", xcyc_b, 2);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
